// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and helpers for the truth-table sequencer.
//   state_t  : sequencer FSM states (2-bit encoding)
//   HOLD_W   : width of the per-vector hold counter
//   tbl_size : number of truth-table entries for a given input count
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned HOLD_W = 8;

  function automatic int unsigned tbl_size(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_hold_timer.sv
// Hold timer: counts cycles while a stimulus vector is applied.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   clear  : synchronous clear of the count (wins over enable)
//   enable : count one cycle
//   tick   : high in the cycle where count == HOLD-1 while enabled
module hold_timer
  import seq_pkg::*;
#(
  parameter int unsigned HOLD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD - 1);

  logic [HOLD_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + HOLD_W'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: on start, drives every input vector in ascending
// order for HOLD cycles each, captures the response of the block under test
// into a truth table and compares it with a golden table.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   start    : one-cycle sweep request, honoured only in IDLE
//   expected : golden table, bit i = expected response to vector i
//   vec_out  : stimulus vector to the block under test
//   resp_in  : response of the block under test
//   busy     : high while a sweep is in progress
//   done     : one-cycle pulse when the sweep completes
//   truth    : captured table, bit i = response sampled for vector i
//   match    : truth == expected, valid from done until next accepted start
module truth_table_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned N_IN = 3,
  parameter int unsigned HOLD = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [tbl_size(N_IN)-1:0] expected,
  output logic [N_IN-1:0]           vec_out,
  input  logic                      resp_in,
  output logic                      busy,
  output logic                      done,
  output logic [tbl_size(N_IN)-1:0] truth,
  output logic                      match
);

  localparam int unsigned     TBL      = tbl_size(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(TBL - 1);

  state_t          state, state_n;
  logic [N_IN-1:0] vec_n;
  logic [TBL-1:0]  truth_n;
  logic            match_q, match_n;
  logic            tbl_eq;
  logic            tick;
  logic            timer_clear;
  logic            timer_en;

  assign timer_en    = (state == DRIVE);
  assign timer_clear = (state != DRIVE) || tick;

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .tick   (tick)
  );

  assign tbl_eq = (truth == expected);

  always_comb begin
    state_n = state;
    vec_n   = vec_out;
    truth_n = truth;
    match_n = match_q;
    case (state)
      IDLE: begin
        vec_n = '0;
        if (start) begin
          state_n = DRIVE;
          truth_n = '0;
        end
      end
      DRIVE: begin
        if (tick) begin
          truth_n[vec_out] = resp_in;
          if (vec_out != LAST_VEC) begin
            vec_n = vec_out + N_IN'(1);
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        match_n = tbl_eq;
        state_n = IDLE;
        vec_n   = '0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      vec_out <= '0;
      truth   <= '0;
      match_q <= 1'b0;
    end else begin
      state   <= state_n;
      vec_out <= vec_n;
      truth   <= truth_n;
      match_q <= match_n;
    end
  end

  assign busy = (state == DRIVE);
  assign done = (state == DONE);
  // During DONE the comparison is presented live so that match rises together
  // with done and only sees expected in that cycle; the register then holds it.
  assign match = done ? tbl_eq : match_q;

endmodule
